// File: rtl/reg_access_monitor_pkg.sv
// Shared definitions for reg_access_monitor: register offsets, CTRL/STATUS bit positions
// and the trace FIFO entry layout.
package reg_access_monitor_pkg;
  localparam int TraceIdxW = 5;

  localparam logic [9:0] OffCtrl    = 10'h000;
  localparam logic [9:0] OffStatus  = 10'h004;
  localparam logic [9:0] OffCycle   = 10'h008;
  localparam logic [9:0] OffTrace   = 10'h00C;
  localparam logic [9:0] OffDropped = 10'h010;

  localparam int CtrlEnable   = 0;
  localparam int CtrlSnapshot = 1;
  localparam int CtrlClear    = 2;
  localparam int CtrlIrqEn    = 3;

  localparam int StatOvf   = 0;
  localparam int StatEmpty = 1;
  localparam int StatFull  = 2;

  typedef struct packed {
    logic                 is_write;
    logic [TraceIdxW-1:0] idx;
    logic [25:0]          cycle;
  } trace_entry_t;
endpackage

// File: rtl/reg_access_trace_fifo.sv
// Synchronous FIFO holding trace entries; Depth must be a power of two.
// Push while full and pop while empty are ignored; flush empties it in one cycle.
module reg_access_trace_fifo #(
  parameter int Depth = 16,
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW:0]    wr_ptr;
  logic [PtrW:0]    rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PtrW] != rd_ptr[PtrW]) && (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
  assign rdata = mem[rd_ptr[PtrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push && !full) mem[wr_ptr[PtrW-1:0]] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/reg_access_monitor.sv
// Bus-attached monitor counting per-register read/write events with shadow snapshots.
// Define REG_ACCESS_TRACE_EN to add the event trace FIFO (TRACE/DROPPED registers).
module reg_access_monitor
  import reg_access_monitor_pkg::*;
#(
  parameter int NumRegs      = 32,
  parameter int CntWidth     = 32,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int FifoDepth    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumRegs-1:0]      rd_ev_i,
  input  logic [NumRegs-1:0]      wr_ev_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [DataWidth/8-1:0]  be_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [DataWidth-1:0]    wdata_i,
  output logic                    rvalid_o,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    err_o,
  output logic                    irq_o
);
  logic [CntWidth-1:0]  rd_live [NumRegs];
  logic [CntWidth-1:0]  wr_live [NumRegs];
  logic [CntWidth-1:0]  rd_shd  [NumRegs];
  logic [CntWidth-1:0]  wr_shd  [NumRegs];
  logic                 enable, irq_en, ovf;
  logic [31:0]          cycle_cnt;
  logic [9:0]           off;
  logic [NumRegs-1:0]   wr_eff;
  logic [TraceIdxW-1:0] reg_idx;
  logic [DataWidth-1:0] rd_val;
  logic mapped, writable, cnt_hit, bus_err, do_write, ctrl_wr, do_snap, do_clear;
  logic status_w1c, count_en, sat_hit, fifo_full, fifo_empty;
  logic unused_bits;

  assign off         = addr_i[9:0];
  assign wr_eff      = wr_ev_i & ~NumRegs'(1);  // register 0 writes are never counted
  assign reg_idx     = off[2 +: TraceIdxW];
  assign cnt_hit     = (off[9:8] == 2'b01 || off[9:8] == 2'b10) && off[1:0] == 2'b00
                       && int'(off[7:2]) < NumRegs;
  assign bus_err     = req_i & (~mapped | (we_i & ~writable));
  assign do_write    = req_i & we_i & mapped & writable & (&be_i);
  assign ctrl_wr     = do_write & (off == OffCtrl);
  assign do_snap     = ctrl_wr & wdata_i[CtrlSnapshot];
  assign do_clear    = ctrl_wr & wdata_i[CtrlClear];
  assign status_w1c  = do_write & (off == OffStatus) & wdata_i[StatOvf];
  assign count_en    = enable & ~do_clear;
  assign irq_o       = ovf & irq_en;
  assign unused_bits = ^{addr_i[AddressWidth-1:10], wdata_i[DataWidth-1:4]};

  always_comb begin
    sat_hit = 1'b0;
    for (int r = 0; r < NumRegs; r++) begin
      if (rd_ev_i[r] && rd_live[r] == '1) sat_hit = 1'b1;
      if (wr_eff[r] && wr_live[r] == '1) sat_hit = 1'b1;
    end
  end

`ifdef REG_ACCESS_TRACE_EN
  trace_entry_t         entry;
  logic [31:0]          fifo_rdata, dropped;
  logic [TraceIdxW-1:0] sel_idx;
  logic                 sel_wr, trace_any, push, pop;
  logic [6:0]           ev_num, drop_inc;
  logic [32:0]          drop_sum;

  // Descending scan so the lowest index wins; writes override reads.
  always_comb begin
    sel_idx   = '0;
    sel_wr    = 1'b0;
    trace_any = 1'b0;
    for (int r = NumRegs - 1; r >= 0; r--) begin
      if (rd_ev_i[r]) begin
        sel_idx   = TraceIdxW'(r);
        trace_any = 1'b1;
      end
    end
    for (int r = NumRegs - 1; r >= 1; r--) begin
      if (wr_eff[r]) begin
        sel_idx   = TraceIdxW'(r);
        sel_wr    = 1'b1;
        trace_any = 1'b1;
      end
    end
  end

  assign entry    = {sel_wr, sel_idx, cycle_cnt[25:0]};
  assign push     = count_en & trace_any & ~fifo_full;
  assign pop      = req_i & ~we_i & (off == OffTrace) & ~fifo_empty;
  assign ev_num   = 7'($countones(rd_ev_i)) + 7'($countones(wr_eff));
  assign drop_inc = ev_num - 7'(push);
  assign drop_sum = {1'b0, dropped} + 33'(drop_inc);

  reg_access_trace_fifo #(
    .Depth(FifoDepth),
    .Width($bits(trace_entry_t))
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .flush (do_clear),
    .push  (push),
    .wdata (entry),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || do_clear) dropped <= '0;
    else if (count_en)     dropped <= drop_sum[32] ? '1 : drop_sum[31:0];
  end
`else
  assign fifo_full  = 1'b0;
  assign fifo_empty = 1'b0;
`endif

  always_comb begin
    mapped   = 1'b0;
    writable = 1'b0;
    rd_val   = '0;
    if (off == OffCtrl) begin
      mapped            = 1'b1;
      writable          = 1'b1;
      rd_val[CtrlEnable] = enable;
      rd_val[CtrlIrqEn]  = irq_en;
    end else if (off == OffStatus) begin
      mapped            = 1'b1;
      writable          = 1'b1;
      rd_val[StatOvf]   = ovf;
      rd_val[StatEmpty] = fifo_empty;
      rd_val[StatFull]  = fifo_full;
    end else if (off == OffCycle) begin
      mapped = 1'b1;
      rd_val = DataWidth'(cycle_cnt);
`ifdef REG_ACCESS_TRACE_EN
    end else if (off == OffTrace) begin
      mapped = 1'b1;
      rd_val = fifo_empty ? '0 : DataWidth'(fifo_rdata);
    end else if (off == OffDropped) begin
      mapped = 1'b1;
      rd_val = DataWidth'(dropped);
`endif
    end else if (cnt_hit) begin
      mapped = 1'b1;
      rd_val = off[9] ? DataWidth'(wr_shd[reg_idx]) : DataWidth'(rd_shd[reg_idx]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o  <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
      enable    <= 1'b0;
      irq_en    <= 1'b0;
      ovf       <= 1'b0;
      cycle_cnt <= '0;
      for (int r = 0; r < NumRegs; r++) begin
        rd_live[r] <= '0;
        wr_live[r] <= '0;
        rd_shd[r]  <= '0;
        wr_shd[r]  <= '0;
      end
    end else begin
      rvalid_o <= req_i;
      err_o    <= bus_err;
      rdata_o  <= (req_i & ~we_i & mapped) ? rd_val : '0;
      if (ctrl_wr) begin
        enable <= wdata_i[CtrlEnable];
        irq_en <= wdata_i[CtrlIrqEn];
      end
      // A new overflow in the same cycle as the W1C keeps the flag set.
      if (count_en && sat_hit) ovf <= 1'b1;
      else if (status_w1c)     ovf <= 1'b0;
      if (do_clear)    cycle_cnt <= '0;
      else if (enable) cycle_cnt <= cycle_cnt + 32'd1;
      for (int r = 0; r < NumRegs; r++) begin
        if (do_snap) begin
          rd_shd[r] <= rd_live[r];
          wr_shd[r] <= wr_live[r];
        end
        if (do_clear) begin
          rd_live[r] <= '0;
          wr_live[r] <= '0;
        end else if (enable) begin
          if (rd_ev_i[r] && rd_live[r] != '1) rd_live[r] <= rd_live[r] + CntWidth'(1);
          if (wr_eff[r] && wr_live[r] != '1) wr_live[r] <= wr_live[r] + CntWidth'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_reg_access_monitor.sv
// Bench for reg_access_monitor: a 32b-counter and a 4b-counter instance share stimulus
// and are checked every cycle against an event-level model, plus literal spot checks.
`timescale 1ns/1ps
module tb_reg_access_monitor;
  localparam int N = 32;
`ifdef REG_ACCESS_TRACE_EN
  localparam bit Trace = 1'b1;
`else
  localparam bit Trace = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] rd_ev, wr_ev, addr, wdata;
  logic [3:0]  be;
  logic        rvalid [2];
  logic        err    [2];
  logic        irq    [2];
  logic [31:0] rdata  [2];

  always #5 clk = ~clk;

  reg_access_monitor u_dut32 (
    .clk_i(clk), .rst_i(rst), .rd_ev_i(rd_ev), .wr_ev_i(wr_ev), .req_i(req), .we_i(we),
    .be_i(be), .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
    .err_o(err[0]), .irq_o(irq[0]));

  reg_access_monitor #(.CntWidth(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .rd_ev_i(rd_ev), .wr_ev_i(wr_ev), .req_i(req), .we_i(we),
    .be_i(be), .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
    .err_o(err[1]), .irq_o(irq[1]));

  // Model state: event counts per instance (saturating at that instance's cap).
  longint unsigned cap [2] = '{64'hFFFF_FFFF, 64'd15};
  longint unsigned lv_rd [2][N];
  longint unsigned lv_wr [2][N];
  longint unsigned sh_rd [2][N];
  longint unsigned sh_wr [2][N];
  bit              m_en, m_irq_en;
  bit              m_ovf [2];
  int unsigned     m_cycle, m_dropped;
  int unsigned     m_q [$];
  bit              e_rvalid, e_err;
  logic [31:0]     e_rdata [2];
  bit              e_irq [2];
  int              total = 0;
  int              bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [9:0]      off;
    int              r, pre_size;
    bit              mapped, writable, do_wr, snap, clr, pop;
    bit              ovf_set [2];
    int unsigned     cyc0;
    int unsigned     evq [$];
    longint unsigned dsum;
    logic [31:0]     rv [2];
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < N; k++) begin
          lv_rd[i][k] = 0; lv_wr[i][k] = 0; sh_rd[i][k] = 0; sh_wr[i][k] = 0;
        end
        m_ovf[i] = 0; e_irq[i] = 0; e_rdata[i] = '0;
      end
      m_en = 0; m_irq_en = 0; m_cycle = 0; m_dropped = 0; m_q.delete();
      e_rvalid = 0; e_err = 0;
      return;
    end
    off = addr[9:0];
    r = int'(off[7:2]);
    mapped = 0; writable = 0; rv[0] = '0; rv[1] = '0;
    for (int i = 0; i < 2; i++) begin
      if (off == 10'h000) begin
        mapped = 1; writable = 1; rv[i] = {28'd0, m_irq_en, 2'b00, m_en};
      end else if (off == 10'h004) begin
        mapped = 1; writable = 1;
        rv[i] = {29'd0, Trace && m_q.size() == 16, Trace && m_q.size() == 0, m_ovf[i]};
      end else if (off == 10'h008) begin
        mapped = 1; rv[i] = m_cycle;
      end else if (Trace && off == 10'h00C) begin
        mapped = 1; rv[i] = (m_q.size() > 0) ? m_q[0] : 32'd0;
      end else if (Trace && off == 10'h010) begin
        mapped = 1; rv[i] = m_dropped;
      end else if ((off[9:8] == 2'b01 || off[9:8] == 2'b10) && off[1:0] == 2'b00 && r < N) begin
        mapped = 1; rv[i] = off[9] ? 32'(sh_wr[i][r]) : 32'(sh_rd[i][r]);
      end
    end
    e_rvalid = req;
    e_err = req && (!mapped || (we && !writable));
    for (int i = 0; i < 2; i++) e_rdata[i] = (req && !we && mapped) ? rv[i] : 32'd0;

    do_wr = req && we && mapped && writable && be == 4'hF;
    snap = do_wr && off == 10'h000 && wdata[1];
    clr  = do_wr && off == 10'h000 && wdata[2];
    pop  = req && !we && Trace && off == 10'h00C;
    ovf_set[0] = 0; ovf_set[1] = 0;
    if (snap)
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < N; k++) begin sh_rd[i][k] = lv_rd[i][k]; sh_wr[i][k] = lv_wr[i][k]; end
    cyc0 = m_cycle;
    pre_size = m_q.size();
    if (pop && pre_size > 0) void'(m_q.pop_front());
    if (m_en && !clr) begin
      // Trace candidates in priority order: writes by ascending index, then reads.
      for (int k = 1; k < N; k++)
        if (wr_ev[k]) evq.push_back(32'h8000_0000 | (k << 26) | (cyc0 & 32'h03FF_FFFF));
      for (int k = 0; k < N; k++)
        if (rd_ev[k]) evq.push_back((k << 26) | (cyc0 & 32'h03FF_FFFF));
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < N; k++) begin
          if (rd_ev[k]) begin
            if (lv_rd[i][k] < cap[i]) lv_rd[i][k]++; else ovf_set[i] = 1;
          end
          if (k > 0 && wr_ev[k]) begin
            if (lv_wr[i][k] < cap[i]) lv_wr[i][k]++; else ovf_set[i] = 1;
          end
        end
      if (Trace && evq.size() > 0) begin
        dsum = longint'(m_dropped) + evq.size();
        if (pre_size < 16) begin
          m_q.push_back(evq[0]);
          dsum = dsum - 1;
        end
        m_dropped = (dsum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(dsum);
      end
      m_cycle++;
    end
    if (clr) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < N; k++) begin lv_rd[i][k] = 0; lv_wr[i][k] = 0; end
      m_cycle = 0; m_q.delete(); m_dropped = 0;
    end
    if (do_wr && off == 10'h004 && wdata[0]) begin m_ovf[0] = 0; m_ovf[1] = 0; end
    for (int i = 0; i < 2; i++) m_ovf[i] = m_ovf[i] | ovf_set[i];
    if (do_wr && off == 10'h000) begin m_en = wdata[0]; m_irq_en = wdata[3]; end
    for (int i = 0; i < 2; i++) e_irq[i] = m_ovf[i] & m_irq_en;
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      chk(i == 0 ? "rvalid32" : "rvalid4", rvalid[i], e_rvalid);
      chk(i == 0 ? "irq32" : "irq4", irq[i], e_irq[i]);
      if (e_rvalid) begin
        chk(i == 0 ? "err32" : "err4", err[i], e_err);
        chk(i == 0 ? "rdata32" : "rdata4", rdata[i], e_rdata[i]);
      end
    end
  endtask

  task automatic step(input logic [31:0] r_ev, input logic [31:0] w_ev, input logic rq,
                      input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input logic rs);
    rd_ev = r_ev; wr_ev = w_ev; req = rq; we = w; be = b; addr = a; wdata = d; rst = rs;
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic wr(input logic [9:0] off, input logic [31:0] d);
    step(32'd0, 32'd0, 1'b1, 1'b1, 4'hF, {22'd0, off}, d, 1'b0);
  endtask

  task automatic rd(input logic [9:0] off, output logic [31:0] d0, output logic [31:0] d1,
                    output logic e);
    step(32'd0, 32'd0, 1'b1, 1'b0, 4'hF, {22'd0, off}, 32'd0, 1'b0);
    d0 = rdata[0]; d1 = rdata[1]; e = err[0];
  endtask

  task automatic ev(input logic [31:0] r, input logic [31:0] w, input int n);
    repeat (n) step(r, w, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] d0, d1, a, d, r_ev, w_ev, tmp;
    logic        e;
    logic [9:0]  off;
    logic [3:0]  b;

    // Request during reset must not produce a response.
    step(32'd0, 32'd0, 1'b1, 1'b0, 4'hF, 32'd0, 32'd0, 1'b1);
    chk("reset_rvalid", rvalid[0], 0);
    chk("reset_irq", irq[1], 0);
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1);

    wr(10'h000, 32'h1);
    ev(32'h20, 32'h0, 3);
    wr(10'h000, 32'h3);
    rd(10'h114, d0, d1, e);
    chk("t1_rdcnt5", d0, 3); chk("t1_err", e, 0);
    rd(10'h118, d0, d1, e);
    chk("t1_rdcnt6", d0, 0);

    ev(32'h0, 32'h3, 4);
    wr(10'h000, 32'h3);
    rd(10'h200, d0, d1, e); chk("t2_wrcnt0", d0, 0);
    rd(10'h204, d0, d1, e); chk("t2_wrcnt1", d0, 4); chk("t2_wrcnt1_w4", d1, 4);

    wr(10'h000, 32'h5);
    ev(32'h4, 32'h0, 17);
    wr(10'h000, 32'h3);
    rd(10'h108, d0, d1, e); chk("t3_sat_w4", d1, 15); chk("t3_nosat_w32", d0, 17);
    rd(10'h004, d0, d1, e); chk("t3_ovf_w4", d1[0], 1); chk("t3_ovf_w32", d0[0], 0);
    wr(10'h000, 32'h9);
    chk("t3_irq_set", irq[1], 1);
    wr(10'h004, 32'h1);
    chk("t3_irq_w1c", irq[1], 0);

    ev(32'h8, 32'h0, 2);
    step(32'h8, 32'h0, 1'b1, 1'b1, 4'hF, 32'd0, 32'h7, 1'b0);
    rd(10'h10C, d0, d1, e); chk("t4_shadow_prior", d0, 2);
    wr(10'h000, 32'h3);
    rd(10'h10C, d0, d1, e); chk("t4_live_cleared", d0, 0);

    rd(10'h300, d0, d1, e); chk("t5_rd_err", e, 1); chk("t5_rd_data", d0, 0);
    wr(10'h100, 32'h5);
    chk("t5_wr_ro_err", err[0], 1);
    step(32'd0, 32'd0, 1'b1, 1'b1, 4'h3, 32'd0, 32'h0, 1'b0);
    chk("t5_partial_noerr", err[0], 0);
    rd(10'h000, d0, d1, e); chk("t5_ctrl_kept", d0, 1);

`ifdef REG_ACCESS_TRACE_EN
    wr(10'h000, 32'h5);
    ev(32'h0, 32'h6, 1);
    rd(10'h010, d0, d1, e); chk("t6_dropped", d0, 1);
    rd(10'h00C, d0, d1, e); tmp = d0; chk("t6_entry_hdr", tmp[31:26], 6'b100001);
    ev(32'h1, 32'h0, 16);
    rd(10'h004, d0, d1, e); chk("t6_fifo_full", d0[2], 1);
`else
    rd(10'h00C, d0, d1, e); chk("t6_trace_unmapped", e, 1);
    rd(10'h010, d0, d1, e); chk("t6_dropped_unmapped", e, 1);
    rd(10'h004, d0, d1, e); chk("t6_status_fifo_bits", d0[2:1], 0);
`endif

    for (int c = 0; c < 3000; c++) begin
      r_ev = ($urandom_range(0, 9) < 3) ? 32'd0 : ($urandom() & $urandom() & $urandom());
      w_ev = ($urandom_range(0, 9) < 3) ? 32'd0 : ($urandom() & $urandom() & $urandom());
      case ($urandom_range(0, 11))
        0, 10, 11: off = 10'h000;
        1:         off = 10'h004;
        2:         off = 10'h008;
        3:         off = 10'h00C;
        4:         off = 10'h010;
        5:         off = 10'h014;
        6:         off = 10'(10'h100 + 4 * $urandom_range(0, 31));
        7:         off = 10'(10'h200 + 4 * $urandom_range(0, 31));
        8:         off = 10'(10'h300 + 4 * $urandom_range(0, 63));
        default:   off = 10'(10'h100 + 4 * $urandom_range(0, 31) + $urandom_range(1, 3));
      endcase
      tmp = $urandom();
      a = {tmp[31:10], off};
      if (off == 10'h000)
        d = {28'd0, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) != 0)};
      else
        d = $urandom();
      b = ($urandom_range(0, 19) < 17) ? 4'hF : 4'($urandom());
      step(r_ev, w_ev, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b, a, d,
           $urandom_range(0, 399) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
